registrador: RTL and testbench

REGISTRADOR -- requirements
Module: registrador

---
 rtl/registrador.sv | 38 +++
 tb/tb_registrador.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/registrador.sv
// registrador: WIDTH-bit load-enable register with asynchronous active-low reset.
//
// Ports:
//   clk    - single clock; all loads happen on its rising edge
//   reset  - asynchronous, active-low; forces out to RESET_VALUE immediately
//   enable - active-high load enable; when low the register holds
//   in     - data captured on a rising edge while enable is high
//   out    - registered data, driven straight from the flip-flops
//
// All WIDTH bits load or hold together. Reset wins over enable.
module registrador #(
  parameter int              WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] out_r;

  // Data register: async clear to RESET_VALUE, load on enable, otherwise hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_r <= RESET_VALUE;
    end else if (enable) begin
      out_r <= in;
    end else begin
      out_r <= out_r;
    end
  end

  // No logic between the flip-flops and the port.
  assign out = out_r;

endmodule

// File: tb/tb_registrador.sv
// Scoreboard bench for registrador (WIDTH=4, RESET_VALUE=0).
// Stimulus computes the expected out for every DUT event (rising clk edge or
// reset assertion) from a behavioural model and queues it; the monitor pops
// one entry per event and compares.
module tb_registrador;

  localparam int         W  = 4;
  localparam logic [3:0] RV = 4'b0000;

  typedef struct {
    logic [W-1:0] val;
    string        tag;
  } exp_t;

  logic         clk;
  logic         reset;
  logic         enable;
  logic [W-1:0] din;
  logic [W-1:0] dout;

  exp_t         exp_q[$];
  int           total;
  int           bad;
  logic [W-1:0] model;   // value the register should hold after the last event

  registrador #(.WIDTH(W), .RESET_VALUE(RV)) dut (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .in    (din),
    .out   (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every rising edge and every reset assertion is an output event.
  always @(posedge clk or negedge reset) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (dout !== e.val) begin
        bad++;
        $display("FAIL %s: out=%b expected=%b at t=%0t", e.tag, dout, e.val, $time);
      end
    end
  end

  // One clock cycle: drive inputs at the falling edge, predict the next rising edge.
  task automatic cycle(input logic en, input logic [W-1:0] d, input logic rst, input string tag);
    @(negedge clk);
    if (reset === 1'b1 && rst == 1'b0) begin
      exp_q.push_back('{RV, {tag, "_async"}});
      model = RV;
    end
    if (rst == 1'b0)     model = RV;
    else if (en == 1'b1) model = d;
    exp_q.push_back('{model, tag});
    enable = en;
    din    = d;
    reset  = rst;
  endtask

  // Assert reset mid-cycle (between edges) and leave it asserted.
  task automatic assert_mid(input string tag);
    @(negedge clk);
    #2;
    model = RV;
    exp_q.push_back('{RV, {tag, "_now"}});
    exp_q.push_back('{RV, {tag, "_edge"}});
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    logic         en_r;
    logic [W-1:0] d_r;
    logic         rst_r;
    total  = 0;
    bad    = 0;
    model  = RV;
    reset  = 1'b1;
    enable = 1'b0;
    din    = 4'b0000;

    // Async reset from an undefined register, held across edges with enable high.
    assert_mid("init_reset");
    cycle(1'b1, 4'b1111, 1'b0, "reset_hold");

    // Load two consecutive values.
    cycle(1'b1, 4'b1010, 1'b1, "load_1010");
    cycle(1'b1, 4'b0001, 1'b1, "load_0001");

    // Hold with enable low while in changes.
    cycle(1'b0, 4'b1111, 1'b1, "hold_1111");
    cycle(1'b0, 4'b0101, 1'b1, "hold_0101");

    // Re-enable.
    cycle(1'b1, 4'b0101, 1'b1, "reenable_0101");

    // Priority: reset low with enable high for several edges.
    cycle(1'b1, 4'b1111, 1'b0, "prio_1");
    cycle(1'b1, 4'b1111, 1'b0, "prio_2");
    cycle(1'b1, 4'b1111, 1'b0, "prio_3");
    cycle(1'b1, 4'b1111, 1'b1, "prio_release_load");

    // Reset mid-stream with enable high, then resume.
    cycle(1'b1, 4'b0101, 1'b1, "stream_0101");
    assert_mid("midstream_reset");
    cycle(1'b1, 4'b0011, 1'b1, "resume_0011");
    cycle(1'b1, 4'b1100, 1'b1, "resume_1100");

    // Randomised traffic, including occasional sync-edge and mid-cycle resets.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0 && reset === 1'b1) begin
        assert_mid("rand_mid");
      end else begin
        en_r  = 1'($urandom_range(0, 1));
        d_r   = 4'($urandom_range(0, 15));
        rst_r = ($urandom_range(0, 9) == 0) ? 1'b0 : 1'b1;
        cycle(en_r, d_r, rst_r, "rand");
      end
    end

    // Let the last predictions drain, then every prediction must be consumed.
    @(negedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
